// File: rtl/uart_frame_seq_pkg.sv
// Shared definitions for the UART frame sequencer: FSM state encoding and parity-type constants.
package uart_frame_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_frame_seq_sync_cmd_fifo.sv
// Single-clock command FIFO with first-word-fall-through read data and an occupancy count.
module sync_cmd_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  push, pop;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == LW'(DEPTH));
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign level_o   = level_q;

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_frame_seq.sv
// UART transmit sequencer: queues command bytes and serialises them as start/data/parity/stop frames with an idle gap.
module uart_frame_seq
  import uart_frame_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_W      = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       BIT_TICK,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic                       STOP2,
  input  logic [GAP_W-1:0]           GAP,
  input  logic [DATA_WIDTH-1:0]      WR_DATA,
  input  logic                       WR_VLD,
  output logic                       WR_RDY,
  output logic                       TX_OUT,
  output logic                       BUSY,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       FRAME_DONE
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty, fifo_full;
  logic                  pop;

  state_e                state_q, state_d;
  logic                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  launch;
  logic                  done;

  sync_cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .wr_en_i   (WR_VLD),
    .wr_data_i (WR_DATA),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .level_o   (LEVEL),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign WR_RDY     = !fifo_full;
  assign TX_OUT     = tx_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = done;
  assign pop        = launch;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    gap_d      = gap_q;
    launch     = 1'b0;
    done       = 1'b0;

    if (BIT_TICK) begin
      case (state_q)
        ST_IDLE: launch = !fifo_empty;
        ST_START: begin
          tx_d      = sh_q[0];
          sh_d      = sh_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            tx_d       = par_en_q ? par_bit_q : 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            tx_d      = sh_q[0];
            sh_d      = sh_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        ST_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done = 1'b1;
            if (gap_q != '0) begin
              gap_cnt_d = GAP_W'(1);
              state_d   = ST_GAP;
            end else if (!fifo_empty) begin
              launch = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == gap_q) begin
            if (!fifo_empty) launch = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Frame launch is shared by IDLE, end of STOP and end of GAP so back-to-back frames need no idle tick.
    if (launch) begin
      sh_d      = fifo_rdata;
      par_bit_d = (^fifo_rdata) ^ (PAR_TYP == PAR_ODD);
      par_en_d  = PAR_EN;
      stop2_d   = STOP2;
      gap_d     = GAP;
      tx_d      = 1'b0;
      state_d   = ST_START;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      gap_cnt_q  <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_seq.sv
// Self-checking bench for uart_frame_seq: line-level reference model plus directed literal checks.
module tb_uart_frame_seq;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int GW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          BIT_TICK = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic [GW-1:0] GAP = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic          WR_VLD = 1'b0;
  logic          WR_RDY, TX_OUT, BUSY, FRAME_DONE;
  logic [2:0]    LEVEL;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_seq #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .GAP_W      (GW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BIT_TICK   (BIT_TICK),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .GAP        (GAP),
    .WR_DATA    (WR_DATA),
    .WR_VLD     (WR_VLD),
    .WR_RDY     (WR_RDY),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .LEVEL      (LEVEL),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each popped byte expands into a list of line bit periods.
  typedef struct packed { logic b; logic last; } el_t;
  el_t          line_q[$];
  logic [7:0]   fifo_m[$];
  el_t          cur = '{b: 1'b1, last: 1'b0};
  bit           cur_v = 1'b0;

  function automatic void build(input logic [7:0] d);
    line_q.push_back('{b: 1'b0, last: 1'b0});
    for (int i = 0; i < DW; i++) line_q.push_back('{b: d[i], last: 1'b0});
    if (PAR_EN) line_q.push_back('{b: (^d) ^ PAR_TYP, last: 1'b0});
    if (STOP2) line_q.push_back('{b: 1'b1, last: 1'b0});
    line_q.push_back('{b: 1'b1, last: 1'b1});
    for (int i = 0; i < int'(GAP); i++) line_q.push_back('{b: 1'b1, last: 1'b0});
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      line_q.delete();
      fifo_m.delete();
      cur_v = 1'b0;
      cur   = '{b: 1'b1, last: 1'b0};
    end else begin
      bit rdy;
      rdy = (fifo_m.size() < DP);
      if (BIT_TICK) begin
        if (line_q.size() == 0 && fifo_m.size() > 0) build(fifo_m.pop_front());
        if (line_q.size() > 0) begin
          cur   = line_q.pop_front();
          cur_v = 1'b1;
        end else begin
          cur   = '{b: 1'b1, last: 1'b0};
          cur_v = 1'b0;
        end
      end
      if (WR_VLD && rdy) fifo_m.push_back(WR_DATA);
    end
  end

  always @(negedge CLK) begin
    chk("model_tx",    int'(TX_OUT),     int'(cur.b));
    chk("model_busy",  int'(BUSY),       int'(cur_v));
    chk("model_level", int'(LEVEL),      fifo_m.size());
    chk("model_rdy",   int'(WR_RDY),     int'(fifo_m.size() < DP));
    chk("model_done",  int'(FRAME_DONE), int'(BIT_TICK && cur_v && cur.last));
  end

  // Tick log: fdl[i] = FRAME_DONE during tick i, txl[i] = TX_OUT after tick i.
  logic txl[0:63];
  logic fdl[0:63];
  int   nlog;

  task automatic do_tick(output logic fd, output logic tx);
    @(posedge CLK); #1;
    BIT_TICK = 1'b1;
    #1 fd = FRAME_DONE;
    @(posedge CLK); #1;
    BIT_TICK = 1'b0;
    tx = TX_OUT;
  endtask

  task automatic run_ticks(input int n);
    logic fd, tx;
    for (int i = 0; i < n; i++) begin
      do_tick(fd, tx);
      if (nlog < 64) begin
        txl[nlog] = tx;
        fdl[nlog] = fd;
      end
      nlog++;
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(posedge CLK); #1;
    WR_DATA = d;
    WR_VLD  = 1'b1;
    @(posedge CLK); #1;
    WR_VLD  = 1'b0;
  endtask

  task automatic cfg(input logic pe, input logic pt, input logic s2, input logic [GW-1:0] g);
    PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; GAP = g;
  endtask

  initial begin
    int cnt;
    #23;
    chk("rst_tx", int'(TX_OUT), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_rdy", int'(WR_RDY), 1);
    chk("rst_level", int'(LEVEL), 0);
    chk("rst_done", int'(FRAME_DONE), 0);
    @(posedge CLK); #2 RST_N = 1'b1;

    // 0xAA with even parity: 11 line periods, done on the tick ending the stop bit
    begin
      logic exp_aa [0:10];
      exp_aa = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
      cfg(1'b1, 1'b0, 1'b0, '0);
      push(8'hAA);
      nlog = 0;
      run_ticks(13);
      for (int i = 0; i < 11; i++) chk($sformatf("aa_tx%0d", i), int'(txl[i]), int'(exp_aa[i]));
      chk("aa_done_early", int'(fdl[10]), 0);
      chk("aa_done", int'(fdl[11]), 1);
      chk("aa_idle_busy", int'(BUSY), 0);
    end

    // 0x05 odd parity
    cfg(1'b1, 1'b1, 1'b0, '0);
    push(8'h05);
    nlog = 0;
    run_ticks(13);
    chk("odd_par", int'(txl[9]), 1);

    // back-to-back 0xBB, 0x02 with no idle
    cfg(1'b1, 1'b0, 1'b0, '0);
    push(8'hBB);
    push(8'h02);
    nlog = 0;
    run_ticks(24);
    chk("b2b_par1", int'(txl[9]), 0);
    chk("b2b_stop1", int'(txl[10]), 1);
    chk("b2b_start2", int'(txl[11]), 0);
    chk("b2b_done1", int'(fdl[11]), 1);
    chk("b2b_par2", int'(txl[20]), 1);
    chk("b2b_done2", int'(fdl[22]), 1);

    // fill past DEPTH with ticks held off
    cfg(1'b0, 1'b0, 1'b0, '0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    chk("full_level", int'(LEVEL), 4);
    chk("full_rdy", int'(WR_RDY), 0);
    nlog = 0;
    run_ticks(46);
    cnt = 0;
    for (int i = 0; i < 46; i++) if (fdl[i]) cnt++;
    chk("full_frames", cnt, 4);
    chk("full_d0", int'(txl[1]), 1);
    chk("full_d1", int'(txl[2]), 0);
    chk("full_empty", int'(LEVEL), 0);

    // two stop bits and a 3-period gap
    cfg(1'b0, 1'b0, 1'b1, 4'd3);
    push(8'h77);
    push(8'h03);
    nlog = 0;
    run_ticks(30);
    chk("gap_d7", int'(txl[8]), 0);
    chk("gap_stop1", int'(txl[9]), 1);
    chk("gap_stop2", int'(txl[10]), 1);
    chk("gap_done", int'(fdl[11]), 1);
    for (int i = 11; i < 14; i++) chk($sformatf("gap_idle%0d", i), int'(txl[i]), 1);
    chk("gap_start2", int'(txl[14]), 0);

    // asynchronous reset during data bit 4
    cfg(1'b0, 1'b0, 1'b0, '0);
    push(8'h00);
    push(8'h5A);
    nlog = 0;
    run_ticks(6);
    chk("pre_rst_tx", int'(TX_OUT), 0);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_tx", int'(TX_OUT), 1);
    chk("arst_level", int'(LEVEL), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_rdy", int'(WR_RDY), 1);
    @(posedge CLK); #2 RST_N = 1'b1;
    nlog = 0;
    run_ticks(15);
    cnt = 0;
    for (int i = 0; i < 15; i++) if (!txl[i]) cnt++;
    chk("post_rst_silent", cnt, 0);

    // config change mid-frame applies only to the next frame
    cfg(1'b1, 1'b0, 1'b0, '0);
    push(8'h01);
    push(8'h01);
    nlog = 0;
    run_ticks(3);
    PAR_TYP = 1'b1;
    STOP2   = 1'b1;
    run_ticks(23);
    chk("cfg_par1", int'(txl[9]), 1);
    chk("cfg_start2", int'(txl[11]), 0);
    chk("cfg_par2", int'(txl[20]), 0);
    chk("cfg_stop2a", int'(txl[21]), 1);
    chk("cfg_done_early", int'(fdl[22]), 0);
    chk("cfg_done2", int'(fdl[23]), 1);

    repeat (4) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_seq.md
UART_FRAME_SEQ -- requirements
Module: uart_frame_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 SHALL have parameter GAP_W, default 4: width of the inter-frame idle count.
REQ-004 CLK  in  1  single clock; all logic in this one domain.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 BIT_TICK  in  1  one-CLK pulse per UART bit period; all bit-level timing advances only on it.
REQ-007 PAR_EN  in  1  1 = append parity bit.
REQ-008 PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-009 STOP2  in  1  1 = two stop bits, 0 = one.
REQ-010 GAP  in  GAP_W  idle (mark) bit periods inserted after each frame.
REQ-011 WR_DATA  in  DATA_WIDTH  command byte to enqueue.
REQ-012 WR_VLD  in  1  write request.
REQ-013 WR_RDY  out  1  FIFO can accept; equals (LEVEL < DEPTH).
REQ-014 TX_OUT  out  1  registered serial line, idle high.
REQ-015 BUSY  out  1  high in any state other than IDLE.
REQ-016 LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-017 FRAME_DONE  out  1  one-CLK pulse at the end of the last stop bit of each frame.

Function
REQ-018 SHALL push WR_DATA on a CLK edge where WR_VLD && WR_RDY; a write while WR_RDY=0 SHALL be dropped with no state change.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, GAP; every state change except one caused by reset SHALL occur only on a CLK edge with BIT_TICK=1.
REQ-020 IDLE->START on BIT_TICK when LEVEL>0: pop the head entry, latch PAR_EN, PAR_TYP, STOP2 and GAP, drive TX_OUT=0.
REQ-021 Config inputs SHALL be ignored mid-frame; the latched copies apply to the whole frame, including its GAP.
REQ-022 START->DATA: DATA SHALL send DATA_WIDTH bits LSB first, one per tick, counted by a bit counter.
REQ-023 After the last data bit: go to PARITY if latched PAR_EN=1, else go to STOP.
REQ-024 Parity bit SHALL be XOR of the payload (even), inverted when latched PAR_TYP=1 (odd).
REQ-025 STOP SHALL drive 1 for 1 tick, or 2 ticks when latched STOP2=1.
REQ-026 FRAME_DONE SHALL pulse on the tick that ends STOP; the FSM then moves to GAP if latched GAP>0, else to IDLE.
REQ-027 GAP SHALL drive 1 for GAP ticks, then go to IDLE.
REQ-028 Back-to-back frames: with GAP=0 and LEVEL>0, the next START SHALL begin on the tick after STOP ends.
REQ-029 Frame length SHALL be 1+DATA_WIDTH+PAR_EN+1+STOP2 ticks.
REQ-030 A push and a pop in the same cycle SHALL leave LEVEL unchanged.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 A byte pushed into an empty FIFO SHALL NOT be popped before the next CLK edge.

Reset
REQ-033 While RST_N=0: TX_OUT=1, BUSY=0, WR_RDY=1, LEVEL=0, FRAME_DONE=0, FSM=IDLE, pointers and counters zero.
REQ-034 Reset mid-frame SHALL abort the frame immediately, forcing TX_OUT high, and SHALL discard all FIFO contents.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the parity-type constants (EVEN=0, ODD=1).
REQ-036 The FIFO SHALL be a sub-module, sync_cmd_fifo (parameters DATA_WIDTH and DEPTH; outputs level and empty/full); serializer and FSM SHALL stay in uart_frame_seq.

Verification
REQ-037 Push 0xAA, PAR_EN=1, PAR_TYP=0, STOP2=0, GAP=0 -> TX_OUT per tick 0,0,1,0,1,0,1,0,1,0,1 (11 ticks); FRAME_DONE on tick 11.
REQ-038 Push 0x05, PAR_EN=1, PAR_TYP=1 -> parity bit = 1; push 0xBB then 0x02 with PAR_EN=1, PAR_TYP=0, GAP=0 -> two contiguous 11-tick frames, no idle between them.
REQ-039 DEPTH=4, BIT_TICK held 0, 5 writes -> LEVEL=4, WR_RDY=0, 5th byte dropped; enable ticks -> exactly 4 frames with the first 4 bytes in order.
REQ-040 PAR_EN=0, STOP2=1, GAP=3, push 0x77 then 0x03 -> frames of 11 ticks (start, 8 data, 2 stop), 3 high ticks between them.
REQ-041 Assert RST_N=0 during data bit 4 -> TX_OUT=1 with no CLK edge, LEVEL=0, BUSY=0; after release, no frame until a new write.
REQ-042 Change PAR_TYP and STOP2 mid-frame -> current frame unaffected; the next frame uses the new values.
